// File: rtl/id_stage_pipelined_if.sv
// ID/EX boundary bundle: everything the decode stage hands to EXE, all registered.
// The stage drives it through the master modport; EXE reads it through the slave modport.
interface id_stage_pipelined_if #(
   parameter int unsigned WORD_WIDTH   = 32,
   parameter int unsigned REG_ADDR_LEN = 4
);
   logic [WORD_WIDTH-1:0]   pc_out;
   logic [WORD_WIDTH-1:0]   val_rn;
   logic [WORD_WIDTH-1:0]   val_rm;
   logic [23:0]             imm24;
   logic [11:0]             shift_operand;
   logic [REG_ADDR_LEN-1:0] dest;
   logic [REG_ADDR_LEN-1:0] src1;
   logic [REG_ADDR_LEN-1:0] src2;
   logic [3:0]              exe_cmd;
   logic                    mem_read;
   logic                    mem_write;
   logic                    wb_en_out;
   logic                    imm;
   logic                    b;
   logic                    s_out;
   logic                    valid;

   modport master (
      output pc_out, val_rn, val_rm, imm24, shift_operand, dest, src1, src2,
             exe_cmd, mem_read, mem_write, wb_en_out, imm, b, s_out, valid
   );

   modport slave (
      input  pc_out, val_rn, val_rm, imm24, shift_operand, dest, src1, src2,
             exe_cmd, mem_read, mem_write, wb_en_out, imm, b, s_out, valid
   );
endinterface

// File: rtl/id_stage_pipelined.sv
// ARM-subset decode stage: register file, control decode, condition check,
// RAW hazard detection and the ID/EX register behind one registered boundary.
module id_stage_pipelined #(
   parameter int unsigned WORD_WIDTH   = 32,
   parameter int unsigned REG_COUNT    = 16,
   parameter int unsigned REG_ADDR_LEN = 4,
   parameter bit          WB_BYPASS    = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    hold,
   input  logic                    flush,
   input  logic [WORD_WIDTH-1:0]   pc_in,
   input  logic [WORD_WIDTH-1:0]   instr_in,
   input  logic [3:0]              status_reg,
   input  logic                    wb_en,
   input  logic [REG_ADDR_LEN-1:0] wb_dest,
   input  logic [WORD_WIDTH-1:0]   wb_value,
   input  logic                    exe_wb_en,
   input  logic                    mem_wb_en,
   input  logic [REG_ADDR_LEN-1:0] exe_dest,
   input  logic [REG_ADDR_LEN-1:0] mem_dest,
   output logic                    hazard,
   id_stage_pipelined_if.master    id_ex
);
   localparam int unsigned RF_DEPTH = 1 << REG_ADDR_LEN;

   logic [WORD_WIDTH-1:0]   rf [RF_DEPTH];
   logic                    wr_ok;
   logic [1:0]              mode;
   logic [3:0]              opcode, cond;
   logic                    s_bit;
   logic [3:0]              exe_cmd_d;
   logic                    mem_read_d, mem_write_d, wb_d, imm_d, b_d, s_d;
   logic [REG_ADDR_LEN-1:0] src1, src2;
   logic [WORD_WIDTH-1:0]   val_rn_d, val_rm_d;
   logic                    use_src1, use_src2, hazard_raw, cond_pass;
   logic                    n_f, z_f, c_f, v_f;

   assign mode   = instr_in[27:26];
   assign opcode = instr_in[24:21];
   assign s_bit  = instr_in[20];
   assign cond   = instr_in[31:28];
   assign {n_f, z_f, c_f, v_f} = status_reg;

   // Indices at or above REG_COUNT never reach the array.
   if (REG_COUNT < RF_DEPTH) begin : g_partial_map
      assign wr_ok = (wb_dest < REG_ADDR_LEN'(REG_COUNT));
   end else begin : g_full_map
      assign wr_ok = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < RF_DEPTH; i++) rf[i] <= WORD_WIDTH'(i);
      end else if (wb_en && wr_ok) begin
         rf[wb_dest] <= wb_value;
      end
   end

   always_comb begin
      exe_cmd_d   = '0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      wb_d        = 1'b0;
      imm_d       = 1'b0;
      b_d         = 1'b0;
      s_d         = 1'b0;
      case (mode)
         2'b00: begin
            imm_d = instr_in[25];
            s_d   = s_bit;
            wb_d  = 1'b1;
            case (opcode)
               4'b1101: exe_cmd_d = 4'b0001;
               4'b1111: exe_cmd_d = 4'b1001;
               4'b0100: exe_cmd_d = 4'b0010;
               4'b0101: exe_cmd_d = 4'b0011;
               4'b0010: exe_cmd_d = 4'b0100;
               4'b0110: exe_cmd_d = 4'b0101;
               4'b0000: exe_cmd_d = 4'b0110;
               4'b1100: exe_cmd_d = 4'b0111;
               4'b0001: exe_cmd_d = 4'b1000;
               4'b1010: begin exe_cmd_d = 4'b0100; wb_d = 1'b0; s_d = 1'b1; end
               4'b1000: begin exe_cmd_d = 4'b0110; wb_d = 1'b0; s_d = 1'b1; end
               default: begin imm_d = 1'b0; s_d = 1'b0; wb_d = 1'b0; end
            endcase
         end
         2'b01: begin
            exe_cmd_d   = 4'b0010;
            imm_d       = instr_in[25];
            mem_read_d  = s_bit;
            wb_d        = s_bit;
            mem_write_d = ~s_bit;
         end
         2'b10:   b_d = 1'b1;
         default: ;
      endcase
   end

   assign src1 = REG_ADDR_LEN'(instr_in[19:16]);
   assign src2 = mem_write_d ? REG_ADDR_LEN'(instr_in[15:12]) : REG_ADDR_LEN'(instr_in[3:0]);

   always_comb begin
      val_rn_d = rf[src1];
      val_rm_d = rf[src2];
      if (WB_BYPASS && wb_en && wb_dest == src1) val_rn_d = wb_value;
      if (WB_BYPASS && wb_en && wb_dest == src2) val_rm_d = wb_value;
   end

   assign use_src1   = ~(b_d || (mode == 2'b00 && (opcode == 4'b1101 || opcode == 4'b1111)));
   assign use_src2   = (mode == 2'b00 && !instr_in[25]) || mem_write_d;
   assign hazard_raw = (use_src1 && ((exe_wb_en && exe_dest == src1) || (mem_wb_en && mem_dest == src1)))
                    || (use_src2 && ((exe_wb_en && exe_dest == src2) || (mem_wb_en && mem_dest == src2)));
   assign hazard     = hazard_raw && !flush;

   always_comb begin
      cond_pass = 1'b0;
      case (cond)
         4'b0000: cond_pass = z_f;
         4'b0001: cond_pass = ~z_f;
         4'b0010: cond_pass = c_f;
         4'b0011: cond_pass = ~c_f;
         4'b0100: cond_pass = n_f;
         4'b0101: cond_pass = ~n_f;
         4'b0110: cond_pass = v_f;
         4'b0111: cond_pass = ~v_f;
         4'b1000: cond_pass = c_f & ~z_f;
         4'b1001: cond_pass = ~c_f | z_f;
         4'b1010: cond_pass = (n_f == v_f);
         4'b1011: cond_pass = (n_f != v_f);
         4'b1100: cond_pass = ~z_f & (n_f == v_f);
         4'b1101: cond_pass = z_f | (n_f != v_f);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Reset, flush, hazard and failed condition all collapse into the same all-zero bubble.
   always_ff @(posedge clk) begin
      if (rst || (!hold && (flush || hazard_raw || !cond_pass))) begin
         id_ex.pc_out        <= '0;
         id_ex.val_rn        <= '0;
         id_ex.val_rm        <= '0;
         id_ex.imm24         <= '0;
         id_ex.shift_operand <= '0;
         id_ex.dest          <= '0;
         id_ex.src1          <= '0;
         id_ex.src2          <= '0;
         id_ex.exe_cmd       <= '0;
         id_ex.mem_read      <= 1'b0;
         id_ex.mem_write     <= 1'b0;
         id_ex.wb_en_out     <= 1'b0;
         id_ex.imm           <= 1'b0;
         id_ex.b             <= 1'b0;
         id_ex.s_out         <= 1'b0;
         id_ex.valid         <= 1'b0;
      end else if (!hold) begin
         id_ex.pc_out        <= pc_in;
         id_ex.val_rn        <= val_rn_d;
         id_ex.val_rm        <= val_rm_d;
         id_ex.imm24         <= instr_in[23:0];
         id_ex.shift_operand <= instr_in[11:0];
         id_ex.dest          <= REG_ADDR_LEN'(instr_in[15:12]);
         id_ex.src1          <= src1;
         id_ex.src2          <= src2;
         id_ex.exe_cmd       <= exe_cmd_d;
         id_ex.mem_read      <= mem_read_d;
         id_ex.mem_write     <= mem_write_d;
         id_ex.wb_en_out     <= wb_d;
         id_ex.imm           <= imm_d;
         id_ex.b             <= b_d;
         id_ex.s_out         <= s_d;
         id_ex.valid         <= 1'b1;
      end
   end
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined: a behavioural model predicts each
// ID/EX load, the prediction is queued at drive time and compared after the edge.
module tb_id_stage_pipelined;
   logic        clk = 1'b0;
   logic        rst, hold, flush;
   logic [31:0] pc_in, instr_in;
   logic [3:0]  status_reg;
   logic        wb_en;
   logic [3:0]  wb_dest;
   logic [31:0] wb_value;
   logic        exe_wb_en, mem_wb_en;
   logic [3:0]  exe_dest, mem_dest;
   logic        hazard;

   id_stage_pipelined_if #(.WORD_WIDTH(32), .REG_ADDR_LEN(4)) id_ex ();

   id_stage_pipelined #(
      .WORD_WIDTH(32), .REG_COUNT(16), .REG_ADDR_LEN(4), .WB_BYPASS(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .hold(hold), .flush(flush),
      .pc_in(pc_in), .instr_in(instr_in), .status_reg(status_reg),
      .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
      .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
      .exe_dest(exe_dest), .mem_dest(mem_dest),
      .hazard(hazard), .id_ex(id_ex)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, rn, rm;
      logic [23:0] imm24;
      logic [11:0] shop;
      logic [3:0]  dest, src1, src2, cmd;
      logic        mr, mw, wb, imm, b, s, valid;
   } idex_t;

   idex_t       sb[$];
   idex_t       last;
   logic [31:0] rf_m [16];
   int unsigned n_vec = 0;
   int unsigned n_miss = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rd(input logic [3:0] idx);
      return (wb_en && wb_dest == idx) ? wb_value : rf_m[idx];
   endfunction

   // ARM condition pairs: odd codes invert the even code below them.
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? ~base : base;
   endfunction

   function automatic idex_t decode(input logic [31:0] ins, input logic [31:0] pc);
      idex_t e;
      logic [3:0] op;
      logic known;
      e = '{default: '0};
      op = ins[24:21];
      known = 1'b1;
      if (ins[27:26] == 2'b00) begin
         case (op)
            4'hD: e.cmd = 4'd1;  4'hF: e.cmd = 4'd9;  4'h4: e.cmd = 4'd2;
            4'h5: e.cmd = 4'd3;  4'h2: e.cmd = 4'd4;  4'h6: e.cmd = 4'd5;
            4'h0: e.cmd = 4'd6;  4'hC: e.cmd = 4'd7;  4'h1: e.cmd = 4'd8;
            4'hA: e.cmd = 4'd4;  4'h8: e.cmd = 4'd6;
            default: known = 1'b0;
         endcase
         if (known) begin
            e.wb  = !(op == 4'hA || op == 4'h8);
            e.s   = ins[20] | !e.wb;
            e.imm = ins[25];
         end
      end else if (ins[27:26] == 2'b01) begin
         e.cmd = 4'd2; e.imm = ins[25];
         e.mr = ins[20]; e.wb = ins[20]; e.mw = !ins[20];
      end else if (ins[27:26] == 2'b10) begin
         e.b = 1'b1;
      end
      e.src1  = ins[19:16];
      e.src2  = e.mw ? ins[15:12] : ins[3:0];
      e.rn    = rd(e.src1);
      e.rm    = rd(e.src2);
      e.pc    = pc;
      e.imm24 = ins[23:0];
      e.shop  = ins[11:0];
      e.dest  = ins[15:12];
      e.valid = 1'b1;
      return e;
   endfunction

   function automatic logic hz_raw(input logic [31:0] ins, input idex_t e);
      logic u1, u2;
      u1 = !(e.b || (ins[27:26] == 2'b00 && (ins[24:21] == 4'hD || ins[24:21] == 4'hF)));
      u2 = (ins[27:26] == 2'b00 && !ins[25]) || e.mw;
      return (u1 && ((exe_wb_en && exe_dest == e.src1) || (mem_wb_en && mem_dest == e.src1)))
          || (u2 && ((exe_wb_en && exe_dest == e.src2) || (mem_wb_en && mem_dest == e.src2)));
   endfunction

   task automatic compare(input idex_t e);
      check("pc_out",    id_ex.pc_out,                e.pc);
      check("val_rn",    id_ex.val_rn,                e.rn);
      check("val_rm",    id_ex.val_rm,                e.rm);
      check("imm24",     32'(id_ex.imm24),            32'(e.imm24));
      check("shift_op",  32'(id_ex.shift_operand),    32'(e.shop));
      check("dest",      32'(id_ex.dest),             32'(e.dest));
      check("src1",      32'(id_ex.src1),             32'(e.src1));
      check("src2",      32'(id_ex.src2),             32'(e.src2));
      check("exe_cmd",   32'(id_ex.exe_cmd),          32'(e.cmd));
      check("mem_read",  32'(id_ex.mem_read),         32'(e.mr));
      check("mem_write", 32'(id_ex.mem_write),        32'(e.mw));
      check("wb_en_out", 32'(id_ex.wb_en_out),        32'(e.wb));
      check("imm",       32'(id_ex.imm),              32'(e.imm));
      check("b",         32'(id_ex.b),                32'(e.b));
      check("s_out",     32'(id_ex.s_out),            32'(e.s));
      check("valid",     32'(id_ex.valid),            32'(e.valid));
   endtask

   // Inputs are already settled; predict, queue, clock, then pop and compare.
   task automatic cyc(input logic [31:0] ins);
      idex_t e;
      logic  raw;
      instr_in = ins;
      pc_in    = pc_in + 32'd4;
      #1;
      e   = decode(instr_in, pc_in);
      raw = hz_raw(instr_in, e);
      check("hazard", 32'(hazard), 32'(raw && !flush));
      if (rst)                                              e = '{default: '0};
      else if (hold)                                        e = last;
      else if (flush || raw || !cond_ok(ins[31:28], status_reg)) e = '{default: '0};
      sb.push_back(e);
      last = e;
      if (rst) for (int i = 0; i < 16; i++) rf_m[i] = 32'(i);
      else if (wb_en) rf_m[wb_dest] = wb_value;
      @(posedge clk);
      #1;
      compare(sb.pop_front());
   endtask

   task automatic idle();
      rst = 1'b0; hold = 1'b0; flush = 1'b0; status_reg = 4'b0000;
      wb_en = 1'b0; wb_dest = '0; wb_value = '0;
      exe_wb_en = 1'b0; mem_wb_en = 1'b0; exe_dest = '0; mem_dest = '0;
   endtask

   localparam logic [31:0] ADD123 = 32'hE082_1003;

   initial begin
      logic [31:0] ins;
      idle();
      pc_in = 32'h0000_1000;
      instr_in = '0;
      last = '{default: '0};
      @(negedge clk);

      rst = 1'b1;
      cyc(ADD123);
      cyc(ADD123);
      rst = 1'b0;

      cyc(32'hE085_1003);                       // r5 read straight after reset
      cyc(ADD123);                              // rn=2, rm=3
      exe_dest = 4'd2; exe_wb_en = 1'b1;
      cyc(ADD123);                              // RAW on r2 -> bubble
      exe_wb_en = 1'b0;
      mem_dest = 4'd3; mem_wb_en = 1'b1;
      cyc(ADD123);                              // RAW on r3 from MEM -> bubble
      mem_wb_en = 1'b0;
      cyc(ADD123);
      wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'h0000_DEAD;
      cyc(ADD123);                              // bypassed write
      wb_en = 1'b0;
      cyc(ADD123);                              // written value now in the file
      cyc(32'h0082_1003);                       // ADDEQ, Z=0 -> bubble
      status_reg = 4'b0100;
      cyc(32'h0082_1003);                       // ADDEQ, Z=1 -> loads
      status_reg = 4'b0000;
      cyc(32'hF082_1003);                       // never-execute code
      cyc(32'hE3A0_1005);                       // MOV imm
      cyc(32'hE152_0003);                       // CMP
      cyc(32'hE592_1004);                       // LDR
      exe_dest = 4'd1; exe_wb_en = 1'b1;
      cyc(32'hE582_1004);                       // STR: r1 (rd) is a source -> bubble
      exe_wb_en = 1'b0;
      cyc(32'hE582_1004);
      cyc(32'hEA00_0010);                       // B
      cyc(32'hEF00_0000);                       // undefined mode
      cyc(ADD123);
      hold = 1'b1;
      cyc(32'hE3A0_2007);
      cyc(32'hE152_0003);
      cyc(32'hEA00_0001);
      hold = 1'b0;
      exe_dest = 4'd2; exe_wb_en = 1'b1; flush = 1'b1;
      cyc(ADD123);                              // flush masks hazard, bubble
      flush = 1'b0; rst = 1'b1;
      cyc(ADD123);                              // reset during a stall
      idle();

      for (int k = 0; k < 80; k++) begin
         ins = $urandom;
         if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
         if ($urandom_range(0, 3) != 0) ins[27:26] = 2'($urandom_range(0, 2));
         status_reg = 4'($urandom);
         wb_en      = 1'($urandom);
         wb_dest    = 4'($urandom);
         wb_value   = $urandom;
         exe_wb_en  = ($urandom_range(0, 2) == 0);
         mem_wb_en  = ($urandom_range(0, 2) == 0);
         exe_dest   = 4'($urandom);
         mem_dest   = 4'($urandom);
         hold       = ($urandom_range(0, 7) == 0);
         flush      = ($urandom_range(0, 7) == 0);
         rst        = ($urandom_range(0, 19) == 0);
         cyc(ins);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
